// File: rtl/plot_sink_if.sv
// plot_sink_if
//   Bundles the pixel stream coming from the drawing engines, the
//   framebuffer write port, and the status outputs of plot_sink.
//   slave  : used by plot_sink (consumes pixels, drives the write port)
//   master : used by whoever drives pixels and mem_ready (engines / memory model)
//
//   x, y, color, plot       pixel stream, one pixel per cycle, no back-pressure
//   clear, clear_color      one-cycle full-screen fill request and its colour
//   mem_addr/data/we/ready  framebuffer write handshake
//   busy, overflow          status
//   drop_count, clip_count  saturating event counters
interface plot_sink_if #(
   parameter int ADDR_W  = 17,
   parameter int COLOR_W = 3
);
   logic [15:0]        x;
   logic [15:0]        y;
   logic [COLOR_W-1:0] color;
   logic               plot;
   logic               clear;
   logic [COLOR_W-1:0] clear_color;
   logic [ADDR_W-1:0]  mem_addr;
   logic [COLOR_W-1:0] mem_data;
   logic               mem_we;
   logic               mem_ready;
   logic               busy;
   logic               overflow;
   logic [15:0]        drop_count;
   logic [15:0]        clip_count;

   modport slave (
      input  x, y, color, plot, clear, clear_color, mem_ready,
      output mem_addr, mem_data, mem_we, busy, overflow, drop_count, clip_count
   );

   modport master (
      output x, y, color, plot, clear, clear_color, mem_ready,
      input  mem_addr, mem_data, mem_we, busy, overflow, drop_count, clip_count
   );
endinterface

// File: rtl/plot_sink.sv
// plot_sink
//   Accepts pixel writes from the drawing engines, clips off-screen pixels,
//   converts on-screen ones to linear framebuffer addresses, buffers them in
//   a small FIFO and drains them to the framebuffer over a ready/valid port.
//   Also performs a full-screen clear: drain pending pixels, then write the
//   latched clear colour to every address 0 .. SCREEN_W*SCREEN_H-1.
//
//   clk    system clock
//   reset  synchronous, active-high
//   bus    plot_sink_if.slave: pixel input, clear request, framebuffer write
//          port (mem_addr/mem_data/mem_we/mem_ready) and status outputs
module plot_sink #(
   parameter int SCREEN_W   = 320,
   parameter int SCREEN_H   = 240,
   parameter int ADDR_W     = 17,
   parameter int COLOR_W    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   plot_sink_if.slave  bus
);

   localparam int NPIX  = SCREEN_W * SCREEN_H;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   typedef enum logic [1:0] {RUN, CLR_WAIT, CLR_FILL} state_t;

   state_t             state, state_nxt;

   logic [ADDR_W-1:0]  f_addr [FIFO_DEPTH];
   logic [COLOR_W-1:0] f_data [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count, count_nxt;

   logic [ADDR_W-1:0]  fill_addr;
   logic [COLOR_W-1:0] clr_color;
   logic               busy_q, overflow_q;
   logic [15:0]        drop_q, clip_q;

   logic               on_screen, pix_ok, clip, push, pop, drop, ovf_set;
   logic               fifo_empty, fifo_full, fill_xfer;
   logic [ADDR_W-1:0]  pix_addr, xw, yw;

   logic [ADDR_W-1:0]  mem_addr_c;
   logic [COLOR_W-1:0] mem_data_c;
   logic               mem_we_c;

   // ---------------------------------------------------------------
   // Clip test on the full 16-bit coordinates, then linear address.
   // ---------------------------------------------------------------
   assign on_screen = (bus.x < 16'(SCREEN_W)) && (bus.y < 16'(SCREEN_H));
   assign pix_ok    = bus.plot && on_screen;
   assign clip      = bus.plot && !on_screen;

   assign xw = ADDR_W'(bus.x);
   assign yw = ADDR_W'(bus.y);

   generate
      if (SCREEN_W == 320) begin : g_shift
         // y*320 = y*256 + y*64
         assign pix_addr = (yw << 8) + (yw << 6) + xw;
      end else begin : g_mul
         assign pix_addr = yw * ADDR_W'(SCREEN_W) + xw;
      end
   endgenerate

   // ---------------------------------------------------------------
   // FIFO control. Pixels are only accepted in RUN; a full FIFO still
   // accepts if the head leaves in the same cycle.
   // ---------------------------------------------------------------
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign pop        = (state != CLR_FILL) && !fifo_empty && bus.mem_ready;
   assign push       = pix_ok && (state == RUN) && (!fifo_full || pop);
   assign drop       = pix_ok && !push;
   assign ovf_set    = pix_ok && (state == RUN) && !push;
   assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
   assign fill_xfer  = (state == CLR_FILL) && bus.mem_ready;

   // Storage needs no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         f_addr[wr_ptr] <= pix_addr;
         f_data[wr_ptr] <= bus.color;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Clear sequencer
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (bus.clear)  state_nxt = CLR_WAIT;
         // mem_we is derived from fifo_empty here, so empty also means
         // no write is pending on the port.
         CLR_WAIT: if (fifo_empty) state_nxt = CLR_FILL;
         CLR_FILL: if (fill_xfer && (fill_addr == LAST_ADDR)) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_addr <= '0;
         clr_color <= '0;
      end else begin
         if ((state == RUN) && bus.clear) clr_color <= bus.clear_color;
         if (fill_xfer) begin
            if (fill_addr == LAST_ADDR) fill_addr <= '0;
            else                        fill_addr <= fill_addr + ADDR_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------
   // Write port. Driven purely from registered state so it holds still
   // while mem_ready is low. Address/data read as zero when idle.
   // ---------------------------------------------------------------
   always_comb begin
      mem_we_c   = 1'b0;
      mem_addr_c = '0;
      mem_data_c = '0;
      if (state == CLR_FILL) begin
         mem_we_c   = 1'b1;
         mem_addr_c = fill_addr;
         mem_data_c = clr_color;
      end else if (!fifo_empty) begin
         mem_we_c   = 1'b1;
         mem_addr_c = f_addr[rd_ptr];
         mem_data_c = f_data[rd_ptr];
      end
   end

   assign bus.mem_we   = mem_we_c;
   assign bus.mem_addr = mem_addr_c;
   assign bus.mem_data = mem_data_c;

   // ---------------------------------------------------------------
   // Status. busy is registered from next-cycle state so it lines up
   // with the cycle it describes.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         clip_q     <= '0;
      end else begin
         busy_q <= (state_nxt != RUN) || (count_nxt != '0);
         if (ovf_set) overflow_q <= 1'b1;
         if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
         if (clip && (clip_q != 16'hFFFF)) clip_q <= clip_q + 16'd1;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_q;
   assign bus.clip_count = clip_q;

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink
//   Directed bench for plot_sink: a vector table for single-cycle pixel
//   behaviour, plus hand-written sequences for overflow, full-FIFO
//   push/pop, full-screen clear and reset during a clear.
module tb_plot_sink;

   logic clk = 1'b0;
   logic reset;

   plot_sink_if #(.ADDR_W(17), .COLOR_W(3)) bus ();

   plot_sink #(
      .SCREEN_W(320), .SCREEN_H(240), .ADDR_W(17), .COLOR_W(3), .FIFO_DEPTH(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        plot;
      logic [15:0] x;
      logic [15:0] y;
      logic [2:0]  c;
      logic        rdy;
      logic        we;
      logic [16:0] addr;
      logic [2:0]  data;
      logic        busy;
   } vec_t;

   vec_t tbl[13];

   // transfer monitor: {addr, data} of every accepted write
   logic        mon_en = 1'b0;
   logic [19:0] xq[$];

   always @(negedge clk)
      if (mon_en && bus.mem_we && bus.mem_ready)
         xq.push_back({bus.mem_addr, bus.mem_data});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input int x, input int y, input logic [2:0] c,
                        input logic rdy);
      bus.plot      = p;
      bus.x         = 16'(x);
      bus.y         = 16'(y);
      bus.color     = c;
      bus.mem_ready = rdy;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 3'd0, 1'b0);
      bus.clear = 1'b0;
      bus.clear_color = 3'd0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic vec_t mk(input logic p, input int x, input int y, input int c,
                               input logic rdy, input logic we, input int addr,
                               input int data, input logic busy);
      vec_t v;
      v.plot = p;  v.x = 16'(x);  v.y = 16'(y);  v.c = 3'(c);  v.rdy = rdy;
      v.we = we;   v.addr = 17'(addr);  v.data = 3'(data);  v.busy = busy;
      return v;
   endfunction

   initial begin
      int  mism;
      bit  done;
      logic [19:0] got;

      // plot x y c rdy | we addr data busy  (outputs seen in the same cycle)
      tbl[0]  = mk(1,     5,     2, 3, 1,  0,     0, 0, 0);
      tbl[1]  = mk(0,     0,     0, 0, 1,  1,   645, 3, 1);
      tbl[2]  = mk(0,     0,     0, 0, 1,  0,     0, 0, 0);
      tbl[3]  = mk(1,   320,     0, 5, 1,  0,     0, 0, 0);
      tbl[4]  = mk(1,     0,   240, 5, 1,  0,     0, 0, 0);
      tbl[5]  = mk(1, 65535, 65535, 5, 1,  0,     0, 0, 0);
      tbl[6]  = mk(0,     0,     0, 0, 1,  0,     0, 0, 0);
      tbl[7]  = mk(1,   319,   239, 7, 0,  0,     0, 0, 0);
      tbl[8]  = mk(1,     0,     0, 1, 0,  1, 76799, 7, 1);
      tbl[9]  = mk(0,     0,     0, 0, 0,  1, 76799, 7, 1);
      tbl[10] = mk(0,     0,     0, 0, 1,  1, 76799, 7, 1);
      tbl[11] = mk(0,     0,     0, 0, 1,  1,     0, 1, 1);
      tbl[12] = mk(0,     0,     0, 0, 1,  0,     0, 0, 0);

      // ---------------- reset state ----------------
      do_reset();
      chk("rst_we",    32'(bus.mem_we),     0);
      chk("rst_addr",  32'(bus.mem_addr),   0);
      chk("rst_data",  32'(bus.mem_data),   0);
      chk("rst_busy",  32'(bus.busy),       0);
      chk("rst_ovf",   32'(bus.overflow),   0);
      chk("rst_drop",  32'(bus.drop_count), 0);
      chk("rst_clip",  32'(bus.clip_count), 0);

      // ---------------- vector table ----------------
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].plot, int'(tbl[i].x), int'(tbl[i].y), tbl[i].c, tbl[i].rdy);
         chk($sformatf("vec%0d_we", i),   32'(bus.mem_we),   32'(tbl[i].we));
         chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].addr));
         chk($sformatf("vec%0d_data", i), 32'(bus.mem_data), 32'(tbl[i].data));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy),     32'(tbl[i].busy));
         tick();
      end
      chk("vec_clip", 32'(bus.clip_count), 3);
      chk("vec_drop", 32'(bus.drop_count), 0);
      chk("vec_ovf",  32'(bus.overflow),   0);

      // ---------------- overflow under back-pressure ----------------
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, i, 1, 3'(i), 1'b0);
         tick();
      end
      drive(0, 0, 0, 3'd0, 1'b0);
      chk("ovf_flag", 32'(bus.overflow),   1);
      chk("ovf_drop", 32'(bus.drop_count), 2);
      chk("ovf_busy", 32'(bus.busy),       1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall%0d_we", k),   32'(bus.mem_we),   1);
         chk($sformatf("stall%0d_addr", k), 32'(bus.mem_addr), 320);
         chk($sformatf("stall%0d_data", k), 32'(bus.mem_data), 0);
         tick();
      end
      // full FIFO: push and pop in the same cycle, nothing dropped
      xq.delete();
      mon_en = 1'b1;
      drive(1, 100, 3, 3'd5, 1'b1);
      tick();
      drive(0, 0, 0, 3'd0, 1'b1);
      chk("pp_drop", 32'(bus.drop_count), 2);
      for (int k = 0; k < 15; k++) tick();
      mon_en = 1'b0;
      chk("drain_n", 32'(xq.size()), 9);
      for (int j = 0; j < 9; j++) begin
         got = (j < xq.size()) ? xq[j] : 20'hFFFFF;
         chk($sformatf("drain%0d", j), 32'(got),
             (j < 8) ? 32'({17'(320 + j), 3'(j)}) : 32'({17'd1060, 3'd5}));
      end
      chk("drain_busy", 32'(bus.busy), 0);

      // ---------------- clear sequence ----------------
      do_reset();
      xq.delete();
      mon_en = 1'b1;
      drive(1, 10, 0, 3'd1, 1'b0); tick();
      drive(1, 11, 0, 3'd2, 1'b1); tick();
      drive(1, 12, 0, 3'd3, 1'b0); tick();
      drive(0, 0, 0, 3'd0, 1'b1);
      bus.clear = 1'b1;
      bus.clear_color = 3'd0;
      tick();
      bus.clear = 1'b0;
      bus.clear_color = 3'd7;
      done = 1'b0;
      for (int i = 0; i < 80000 && !done; i++) begin
         if (i == 600 || i == 601) drive(1, 5, 5, 3'd6, 1'b1);
         else if (i == 602)        drive(1, 400, 5, 3'd6, 1'b1);
         else                      drive(0, 0, 0, 3'd0, 1'b1);
         if (bus.mem_we && bus.mem_addr == 17'd76799) begin
            chk("clr_busy_last", 32'(bus.busy), 1);
            tick();
            chk("clr_busy_after", 32'(bus.busy),   0);
            chk("clr_we_after",   32'(bus.mem_we), 0);
            done = 1'b1;
         end else begin
            tick();
         end
      end
      if (!done) chk("clr_timeout", 0, 1);
      mon_en = 1'b0;
      chk("clr_n", 32'(xq.size()), 76803);
      mism = 0;
      for (int j = 0; j < xq.size(); j++) begin
         if (j < 3) begin
            if (xq[j] !== {17'(10 + j), 3'(1 + j)}) mism++;
         end else begin
            if (xq[j] !== {17'(j - 3), 3'd0}) mism++;
         end
      end
      chk("clr_order", 32'(mism), 0);
      chk("clr_drop", 32'(bus.drop_count), 2);
      chk("clr_clip", 32'(bus.clip_count), 1);
      chk("clr_ovf",  32'(bus.overflow),   0);

      // ---------------- reset in the middle of a fill ----------------
      drive(0, 0, 0, 3'd0, 1'b1);
      bus.clear = 1'b1;
      bus.clear_color = 3'd5;
      tick();
      bus.clear = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         if (bus.mem_we && bus.mem_addr == 17'd1000) begin
            chk("rf_data", 32'(bus.mem_data), 5);
            reset = 1'b1;
            tick();
            chk("rf_we", 32'(bus.mem_we), 0);
            reset = 1'b0;
            chk("rf_drop", 32'(bus.drop_count), 0);
            chk("rf_clip", 32'(bus.clip_count), 0);
            chk("rf_ovf",  32'(bus.overflow),   0);
            tick();
            chk("rf_we2",  32'(bus.mem_we), 0);
            chk("rf_busy", 32'(bus.busy),   0);
            done = 1'b1;
         end else begin
            tick();
         end
      end
      if (!done) chk("rf_timeout", 0, 1);
      // back in RUN: a pixel goes straight through
      drive(1, 1, 1, 3'd2, 1'b1);
      tick();
      drive(0, 0, 0, 3'd0, 1'b1);
      chk("rf_run_we",   32'(bus.mem_we),   1);
      chk("rf_run_addr", 32'(bus.mem_addr), 321);
      chk("rf_run_data", 32'(bus.mem_data), 2);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
